inv_shift_rows_stream: RTL

//  Column-serial AES InvShiftRows stage for the decryption datapath; inverse of the forward ShiftRows permutation.

---
 rtl/aes_pkg.sv | 19 +
 rtl/inv_shift_rows.sv | 21 ++
 rtl/inv_shift_rows_stream.sv | 91 +++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES byte-geometry constants and the ShiftRows byte-index tables.
// Table entry i is the source byte index for output byte 15-i, listed from the MSB down.
package aes_pkg;
    localparam int BYTE   = 8;
    localparam int DWORD  = 4 * BYTE;
    localparam int LENGTH = 4 * DWORD;

    localparam int INV_IDX [16] = '{15, 2, 5, 8, 11, 14, 1, 4, 7, 10, 13, 0, 3, 6, 9, 12};
    localparam int FWD_IDX [16] = '{15, 10, 5, 0, 11, 6, 1, 12, 7, 2, 13, 8, 3, 14, 9, 4};

    function automatic logic [LENGTH-1:0] permute(input logic [LENGTH-1:0] st, input logic use_fwd);
        logic [LENGTH-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[LENGTH-1-i*BYTE -: BYTE] = st[(use_fwd ? FWD_IDX[i] : INV_IDX[i])*BYTE +: BYTE];
        end
        return r;
    endfunction
endpackage

// File: rtl/inv_shift_rows.sv
// Combinational 128-bit InvShiftRows permutation of one buffered state.
// With SHIFT_ROWS_FWD_EN defined, a fwd input selects the forward ShiftRows map instead.
module inv_shift_rows
    import aes_pkg::*;
(
    input  logic [LENGTH-1:0] state,
`ifdef SHIFT_ROWS_FWD_EN
    input  logic              fwd,
`endif
    output logic [LENGTH-1:0] perm
);

    always_comb begin
`ifdef SHIFT_ROWS_FWD_EN
        perm = permute(state, fwd);
`else
        perm = permute(state, 1'b0);
`endif
    end

endmodule

// File: rtl/inv_shift_rows_stream.sv
// Column-serial, ping-pong buffered InvShiftRows stage: 4 column beats in, 4 permuted beats out.
// Optional SHIFT_ROWS_FWD_EN adds a per-block fwd input selecting forward ShiftRows.
module inv_shift_rows_stream
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DWORD-1:0] in_col,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SHIFT_ROWS_FWD_EN
    input  logic             fwd,
`endif
    output logic [DWORD-1:0] out_col,
    output logic             out_last
);

    // buf_q[sel][0] is column 0, i.e. the most significant word of the state
    logic [DWORD-1:0]  buf_q [2][4];
    logic              wr_sel, rd_sel;
    logic [1:0]        wr_cnt, rd_cnt;
    logic [1:0]        full;
    logic              wr_fire, rd_fire;
    logic [LENGTH-1:0] rd_state, perm_state;
`ifdef SHIFT_ROWS_FWD_EN
    logic [1:0]        mode_q;
`endif

    assign in_ready  = !full[wr_sel];
    assign out_valid = full[rd_sel];
    assign wr_fire   = in_valid && in_ready;
    assign rd_fire   = out_valid && out_ready;
    assign out_last  = out_valid && (rd_cnt == 2'd3);
    assign rd_state  = {buf_q[rd_sel][0], buf_q[rd_sel][1], buf_q[rd_sel][2], buf_q[rd_sel][3]};

    inv_shift_rows u_perm (
        .state (rd_state),
`ifdef SHIFT_ROWS_FWD_EN
        .fwd   (mode_q[rd_sel]),
`endif
        .perm  (perm_state)
    );

    always_comb begin
        out_col = '0;
        for (int c = 0; c < 4; c++) begin
            if (rd_cnt == 2'(c)) out_col = perm_state[LENGTH-1-c*DWORD -: DWORD];
        end
    end

    // Fill and drain always target different buffers, so both full-bit updates can land together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            wr_cnt <= 2'd0;
            rd_cnt <= 2'd0;
            full   <= 2'b00;
`ifdef SHIFT_ROWS_FWD_EN
            mode_q <= 2'b00;
`endif
            for (int s = 0; s < 2; s++) begin
                for (int c = 0; c < 4; c++) begin
                    buf_q[s][c] <= '0;
                end
            end
        end else begin
            if (wr_fire) begin
                buf_q[wr_sel][wr_cnt] <= in_col;
                wr_cnt                <= wr_cnt + 2'd1;
`ifdef SHIFT_ROWS_FWD_EN
                if (wr_cnt == 2'd0) mode_q[wr_sel] <= fwd;
`endif
                if (wr_cnt == 2'd3) begin
                    full[wr_sel] <= 1'b1;
                    wr_sel       <= !wr_sel;
                end
            end
            if (rd_fire) begin
                rd_cnt <= rd_cnt + 2'd1;
                if (rd_cnt == 2'd3) begin
                    full[rd_sel] <= 1'b0;
                    rd_sel       <= !rd_sel;
                end
            end
        end
    end

endmodule
